// File: rtl/smpl_pkg.sv
// Shared types and sizes for the stimulus sequencer: state encoding and sweep geometry.
package smpl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int NUM_VECTORS = 8;
    localparam int RESULT_W    = 16;
    localparam int VEC_W       = 3;

endpackage

// File: rtl/smpl_dwell_timer.sv
// 16-bit dwell counter: counts while enabled and flags the last cycle of each dwell period.
module smpl_dwell_timer #(
    parameter int unsigned DWELL = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);

    localparam logic [15:0] LAST = 16'(DWELL - 1);

    logic [15:0] count_q;

    assign tc_o = enable_i && !clear_i && (count_q == LAST);

    // The counter wraps to zero on terminal count so the next vector starts a fresh dwell.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear_i || tc_o) begin
            count_q <= '0;
        end else if (enable_i) begin
            count_q <= count_q + 16'd1;
        end
    end

endmodule

// File: rtl/smpl_stim_seq.sv
// Sweeps {a,b,c} through 0..7, holding each vector DWELL cycles and capturing {x,y} per vector.
// Optional golden-compare logic is built only when SMPL_STIM_SEQ_CHECK_EN is defined.
module smpl_stim_seq
    import smpl_pkg::*;
#(
    parameter int unsigned DWELL = 25,
    parameter logic [7:0]  EXP_X = 8'h00,
    parameter logic [7:0]  EXP_Y = 8'h00
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic                x_in,
    input  logic                y_in,
    output logic                a_out,
    output logic                b_out,
    output logic                c_out,
    output logic [VEC_W-1:0]    vec_idx,
    output logic                busy,
    output logic                done,
    output logic                result_valid,
    output logic [RESULT_W-1:0] result,
    output logic                mismatch,
    output logic [3:0]          err_cnt,
    output state_e              state_dbg
);

    state_e                state_q, state_d;
    logic [VEC_W-1:0]      vec_q, vec_d;
    logic [RESULT_W-1:0]   result_q, result_d;
    logic                  rv_q, rv_d;
    logic                  tc;
    logic                  start_accept;
    logic                  sample;

    assign start_accept = (state_q == IDLE) && start && !abort;
    assign sample       = (state_q == DRIVE) && tc;

    smpl_dwell_timer #(.DWELL(DWELL)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  ((state_q != DRIVE) || abort),
        .enable_i (state_q == DRIVE),
        .tc_o     (tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            vec_q    <= '0;
            result_q <= '0;
            rv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            result_q <= result_d;
            rv_q     <= rv_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        result_d = result_q;
        rv_d     = rv_q;
        case (state_q)
            IDLE: begin
                if (start_accept) begin
                    state_d  = DRIVE;
                    vec_d    = '0;
                    result_d = '0;
                    rv_d     = 1'b0;
                end
            end
            DRIVE: begin
                // Abort keeps whatever partial result was captured so far.
                if (abort) begin
                    state_d = IDLE;
                    vec_d   = '0;
                    rv_d    = 1'b0;
                end else if (tc) begin
                    result_d[{vec_q, 1'b0} +: 2] = {x_in, y_in};
                    if (vec_q == VEC_W'(NUM_VECTORS - 1)) begin
                        state_d = DONE;
                        rv_d    = 1'b1;
                    end else begin
                        vec_d = vec_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                vec_d   = '0;
            end
            default: begin
                state_d = IDLE;
                vec_d   = '0;
            end
        endcase
    end

`ifdef SMPL_STIM_SEQ_CHECK_EN
    logic       mismatch_q;
    logic [3:0] err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mismatch_q <= 1'b0;
            err_q      <= '0;
        end else if (start_accept) begin
            mismatch_q <= 1'b0;
            err_q      <= '0;
        end else if (sample && ({x_in, y_in} != {EXP_X[vec_q], EXP_Y[vec_q]})) begin
            mismatch_q <= 1'b1;
            if (err_q != 4'd8) begin
                err_q <= err_q + 4'd1;
            end
        end
    end

    assign mismatch = mismatch_q;
    assign err_cnt  = err_q;
`else
    assign mismatch = 1'b0;
    assign err_cnt  = 4'd0;
`endif

    assign {a_out, b_out, c_out} = vec_q;
    assign vec_idx      = vec_q;
    assign busy         = (state_q == DRIVE);
    assign done         = (state_q == DONE);
    assign result_valid = rv_q;
    assign result       = result_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_smpl_stim_seq.sv
// Directed and randomized sweeps for smpl_stim_seq (DWELL=4 and DWELL=1 instances).
module tb_smpl_stim_seq;
  import smpl_pkg::*;

  localparam int         DW_A  = 4;
  localparam logic [7:0] EXP_X = 8'hC0;
  localparam logic [7:0] EXP_Y_A = 8'hAA;
  localparam logic [7:0] EXP_Y_B = 8'h55;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0;
  logic abort = 1'b0;
  logic rand_mode = 1'b0;
  logic rx = 1'b0;
  logic ry = 1'b0;

  // ---------------- DUT A: DWELL=4 ----------------
  logic        a_a, b_a, c_a, busy_a, done_a, rv_a, mm_a;
  logic [2:0]  vec_a;
  logic [15:0] res_a;
  logic [3:0]  err_a;
  state_e      st_a;
  logic        x_a, y_a;
  assign x_a = rand_mode ? rx : (a_a & b_a);
  assign y_a = rand_mode ? ry : c_a;

  smpl_stim_seq #(.DWELL(DW_A), .EXP_X(EXP_X), .EXP_Y(EXP_Y_A)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .x_in(x_a), .y_in(y_a),
    .a_out(a_a), .b_out(b_a), .c_out(c_a), .vec_idx(vec_a),
    .busy(busy_a), .done(done_a), .result_valid(rv_a), .result(res_a),
    .mismatch(mm_a), .err_cnt(err_a), .state_dbg(st_a)
  );

  // ---------------- DUT B: DWELL=1 ----------------
  logic        a_b, b_b, c_b, busy_b, done_b, rv_b, mm_b;
  logic [2:0]  vec_b;
  logic [15:0] res_b;
  logic [3:0]  err_b;
  state_e      st_b;
  logic        x_b, y_b;
  assign x_b = a_b & b_b;
  assign y_b = c_b;

  smpl_stim_seq #(.DWELL(1), .EXP_X(EXP_X), .EXP_Y(EXP_Y_B)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .x_in(x_b), .y_in(y_b),
    .a_out(a_b), .b_out(b_b), .c_out(c_b), .vec_idx(vec_b),
    .busy(busy_b), .done(done_b), .result_valid(rv_b), .result(res_b),
    .mismatch(mm_b), .err_cnt(err_b), .state_dbg(st_b)
  );

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a sweep on the shared inputs and follow DUT A until done (bounded).
  task automatic sweep_a(input int mid_start_at, input bit rnd, output int done_at);
    done_at = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy_a, 1);
    chk("vec_after_start", vec_a, 0);
    for (int i = 1; i <= 60; i++) begin
      if (i == mid_start_at) start = 1'b1;
      if (rnd) begin
        rx = 1'($urandom_range(0, 1));
        ry = 1'($urandom_range(0, 1));
        if ((i % DW_A) == 0 && i <= 8 * DW_A) exp_q.push_back({rx, ry});
      end
      tick();
      start = 1'b0;
      if (i < 8 * DW_A) begin
        chk("vec_track", vec_a, i / DW_A);
        chk("abc_track", {a_a, b_a, c_a}, i / DW_A);
      end
      if (done_a) begin
        done_at = i;
        break;
      end
    end
  endtask

  // Expected capture of the x=A&B, y=C circuit, built vector by vector.
  function automatic logic [15:0] circuit_result();
    logic [15:0] r;
    logic [2:0]  k;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      k = 3'(i);
      r[2*i +: 2] = {k[2] & k[1], k[0]};
    end
    return r;
  endfunction

  function automatic int exp_errs(input logic [15:0] res, input logic [7:0] ex, input logic [7:0] ey);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++)
      if (res[2*i +: 2] != {ex[i], ey[i]}) n++;
    return (n > 8) ? 8 : n;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int          d;
    logic [15:0] er;
    int          ne;
    bit          seen;
    bit          chk_en;
`ifdef SMPL_STIM_SEQ_CHECK_EN
    chk_en = 1'b1;
`else
    chk_en = 1'b0;
`endif

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_abc", {a_a, b_a, c_a}, 0);
    chk("rst_vec", vec_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_rv", rv_a, 0);
    chk("rst_result", res_a, 0);
    chk("rst_mismatch", mm_a, 0);
    chk("rst_err", err_a, 0);

    // Directed sweep with the A&B / C circuit
    sweep_a(0, 0, d);
    chk("done_at", d, 32);
    chk("done_busy", busy_a, 0);
    chk("done_rv", rv_a, 1);
    chk("done_result", res_a, 16'hE444);
    chk("done_result_model", res_a, circuit_result());
    chk("done_mismatch", mm_a, 0);
    chk("done_err", err_a, 0);
    tick();
    chk("post_done", done_a, 0);
    chk("post_rv_hold", rv_a, 1);
    chk("post_result_hold", res_a, 16'hE444);
    chk("post_abc", {a_a, b_a, c_a}, 0);

    // Start pulsed mid-sweep is ignored
    sweep_a(10, 0, d);
    chk("midstart_done_at", d, 32);
    chk("midstart_result", res_a, 16'hE444);
    tick();

    // Abort during vector 3
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 12; i++) tick();
    chk("pre_abort_vec", vec_a, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy_a, 0);
    chk("abort_abc", {a_a, b_a, c_a}, 0);
    chk("abort_done", done_a, 0);
    chk("abort_rv", rv_a, 0);
    chk("abort_partial", res_a, 16'h0004);
    tick();
    chk("abort_no_done", done_a, 0);
    chk("abort_idle", busy_a, 0);
    sweep_a(0, 0, d);
    chk("restart_done_at", d, 32);
    chk("restart_result", res_a, 16'hE444);
    tick();

    // start with abort in IDLE
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", busy_a, 0);
    chk("start_abort_rv_hold", rv_a, 1);

    // Reset mid-sweep
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_abc", {a_a, b_a, c_a}, 0);
    chk("midrst_vec", vec_a, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_done", done_a, 0);
    chk("midrst_rv", rv_a, 0);
    chk("midrst_result", res_a, 0);
    chk("midrst_mismatch", mm_a, 0);
    chk("midrst_err", err_a, 0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done_a) seen = 1'b1;
    end
    chk("midrst_no_done", seen, 0);

    // DWELL=1 on DUT B
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("dw1_vec0", vec_b, 0);
    d = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i < 8) chk("dw1_abc", {a_b, b_b, c_b}, i);
      if (done_b && d < 0) d = i;
    end
    chk("dw1_done_at", d, 8);
    chk("dw1_result", res_b, 16'hE444);
    chk("dw1_rv", rv_b, 1);
    chk("dw1_mismatch", mm_b, chk_en ? 1 : 0);
    chk("dw1_err", err_b, chk_en ? 8 : 0);
    for (int i = 0; i < 40; i++) tick();

    // Randomized captures on DUT A
    rand_mode = 1'b1;
    for (int s = 0; s < 4; s++) begin
      exp_q.delete();
      sweep_a(0, 1, d);
      chk("rnd_done_at", d, 32);
      chk("rnd_qlen", exp_q.size(), 8);
      er = '0;
      for (int k = 0; k < 8; k++)
        if (exp_q.size() > 0) er[2*k +: 2] = exp_q.pop_front();
      ne = chk_en ? exp_errs(er, EXP_X, EXP_Y_A) : 0;
      chk("rnd_result", res_a, er);
      chk("rnd_rv", rv_a, 1);
      chk("rnd_mismatch", mm_a, (ne > 0) ? 1 : 0);
      chk("rnd_err", err_a, ne);
      for (int i = 0; i < $urandom_range(1, 5); i++) tick();
    end
    rand_mode = 1'b0;

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
